// File: rtl/pilot_input_conditioner.sv
// pilot_input_conditioner: synchronises, debounces and hands off the pad input
// word to oto_pilot over a valid/ready handshake with change mask and overrun.
// Optional feature macro: PILOT_IN_DEBOUNCE_EN (defined: per-bit debounce
// counters; undefined: stable follows the synchronised input every cycle).
module pilot_input_conditioner #(
  parameter int unsigned WIDTH           = 19,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sample_data,
  output logic [WIDTH-1:0] change_mask,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  input  logic             clear_overrun
);

  // Elaboration-time parameter sanity checks
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("pilot_input_conditioner: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("pilot_input_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] last;
  logic             load_c;
  logic             stall_c;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chains, one per pad bit
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef PILOT_IN_DEBOUNCE_EN
  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  // Per-bit debounce: commit a toggle after DEBOUNCE_CYCLES disagreeing samples
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) stable_nxt[i] = ~stable[i];
        else                    cnt_nxt[i]    = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end
`else
  // Debounce disabled: stable tracks the synchronised input directly
  assign stable_nxt = sync;
`endif

  // Debounced state register
  always_ff @(posedge clock) begin
    if (!reset) stable <= '0;
    else        stable <= stable_nxt;
  end

  assign stall_c = sample_valid && !sample_ready;
  assign load_c  = (!sample_valid || sample_ready) && (stable != last);

  // Output word register; coalesces pending commits into one word while stalled
  always_ff @(posedge clock) begin
    if (!reset) begin
      sample_data  <= '0;
      change_mask  <= '0;
      last         <= '0;
      sample_valid <= 1'b0;
    end else if (load_c) begin
      sample_data  <= stable;
      change_mask  <= stable ^ last;
      last         <= stable;
      sample_valid <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  // Sticky overrun: a commit while the consumer stalls; set beats clear
  always_ff @(posedge clock) begin
    if (!reset)                               overrun <= 1'b0;
    else if (stall_c && (stable_nxt != stable)) overrun <= 1'b1;
    else if (clear_overrun)                   overrun <= 1'b0;
  end

endmodule

// File: tb/tb_pilot_input_conditioner.sv
// Directed self-checking bench for pilot_input_conditioner (WIDTH=19,
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4); expectations follow PILOT_IN_DEBOUNCE_EN.
module tb_pilot_input_conditioner;

  localparam int unsigned WIDTH = 19;
`ifdef PILOT_IN_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] sample_data;
  logic [WIDTH-1:0] change_mask;
  logic             sample_valid;
  logic             sample_ready;
  logic             overrun;
  logic             clear_overrun;

  int n_cmp = 0;
  int n_err = 0;

  pilot_input_conditioner #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pin_in       (pin_in),
    .sample_data  (sample_data),
    .change_mask  (change_mask),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int               nvalid;
  int               nw;
  logic [WIDTH-1:0] wdata [4];
  logic [WIDTH-1:0] wmask [4];

  initial begin
    reset         = 1'b0;
    pin_in        = '0;
    sample_ready  = 1'b1;
    clear_overrun = 1'b0;

    // Reset held for three cycles with pins low
    step(3);
    chk("rst_data",    32'(sample_data),  32'h0);
    chk("rst_mask",    32'(change_mask),  32'h0);
    chk("rst_valid",   32'(sample_valid), 32'h0);
    chk("rst_overrun", 32'(overrun),      32'h0);

    // Idle pins after release: no word ever
    reset  = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (sample_valid) nvalid++;
    end
    chk("idle_words", 32'(nvalid), 32'h0);
    chk("idle_data",  32'(sample_data), 32'h0);

    // Bit 0 rises: valid exactly LAT edges later, for one cycle
    pin_in[0] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      step(1);
      chk($sformatf("lat_valid_e%0d", k), 32'(sample_valid), 32'(k == LAT));
      if (k == LAT) begin
        chk("lat_data", 32'(sample_data), 32'h00001);
        chk("lat_mask", 32'(change_mask), 32'h00001);
      end
    end

`ifdef PILOT_IN_DEBOUNCE_EN
    // Three-cycle pulse on bit 5 is filtered
    pin_in[5] = 1'b1;
    step(3);
    pin_in[5] = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (sample_valid) nvalid++;
    end
    chk("short_pulse_words", 32'(nvalid), 32'h0);
    chk("short_pulse_data",  32'(sample_data), 32'h00001);

    // Six-cycle pulse on bit 5 commits rise and fall
    pin_in[5] = 1'b1;
    step(6);
    pin_in[5] = 1'b0;
`else
    // One-cycle glitch on bit 7 propagates as rise and fall
    pin_in[7] = 1'b1;
    step(1);
    pin_in[7] = 1'b0;
`endif
    nw = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (sample_valid && nw < 4) begin
        wdata[nw] = sample_data;
        wmask[nw] = change_mask;
        nw++;
      end
    end
    chk("pulse_words", 32'(nw), 32'd2);
`ifdef PILOT_IN_DEBOUNCE_EN
    chk("pulse_w0_data", 32'(wdata[0]), 32'h00021);
    chk("pulse_w0_mask", 32'(wmask[0]), 32'h00020);
    chk("pulse_w1_data", 32'(wdata[1]), 32'h00001);
    chk("pulse_w1_mask", 32'(wmask[1]), 32'h00020);
`else
    chk("pulse_w0_data", 32'(wdata[0]), 32'h00081);
    chk("pulse_w0_mask", 32'(wmask[0]), 32'h00080);
    chk("pulse_w1_data", 32'(wdata[1]), 32'h00001);
    chk("pulse_w1_mask", 32'(wmask[1]), 32'h00080);
`endif

    // Stalled consumer: word holds, later commit flags overrun and coalesces
    sample_ready = 1'b0;
    pin_in[1]    = 1'b1;
    step(LAT);
    chk("stall_valid", 32'(sample_valid), 32'h1);
    chk("stall_data",  32'(sample_data),  32'h00003);
    chk("stall_mask",  32'(change_mask),  32'h00002);
    step(10 - LAT);
    pin_in[2] = 1'b1;
    step(LAT - 2);
    chk("ovr_before", 32'(overrun), 32'h0);
    step(2);
    chk("ovr_set",     32'(overrun),      32'h1);
    chk("hold_valid",  32'(sample_valid), 32'h1);
    chk("hold_data",   32'(sample_data),  32'h00003);
    chk("hold_mask",   32'(change_mask),  32'h00002);
    sample_ready = 1'b1;
    step(1);
    chk("b2b_valid", 32'(sample_valid), 32'h1);
    chk("b2b_data",  32'(sample_data),  32'h00007);
    chk("b2b_mask",  32'(change_mask),  32'h00004);
    chk("ovr_sticky", 32'(overrun),     32'h1);
    step(1);
    chk("b2b_drop", 32'(sample_valid), 32'h0);
    clear_overrun = 1'b1;
    step(1);
    clear_overrun = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'h0);

    // Reset mid-debounce of bit 3 wipes state; full latency after release
    pin_in[3] = 1'b1;
    step(4);
    reset = 1'b0;
    step(1);
    chk("mid_rst_data",  32'(sample_data),  32'h0);
    chk("mid_rst_mask",  32'(change_mask),  32'h0);
    chk("mid_rst_valid", 32'(sample_valid), 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      step(1);
      chk($sformatf("rel_valid_e%0d", k), 32'(sample_valid), 32'(k == LAT));
      if (k == LAT) begin
        chk("rel_data", 32'(sample_data), 32'h0000F);
        chk("rel_mask", 32'(change_mask), 32'h0000F);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
